elevator_request_latch: RTL and testbench

//  Upstream front end for the 3-floor elevator controller. Synchronises and

---
 rtl/elevator_request_latch.sv | 108 ++++++++++
 tb/tb_elevator_request_latch.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/elevator_request_latch.sv
// Button front end for the 3-floor elevator controller: synchronises and debounces
// six active-low buttons, latches presses as pending requests until served.
module elevator_request_latch #(
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       FB1,
  input  logic       FB2,
  input  logic       FB3,
  input  logic       CALL1,
  input  logic       CALL2,
  input  logic       CALL3,
  input  logic       accept,
  input  logic       svc_valid,
  input  logic [1:0] svc_floor,
  input  logic [1:0] cur_floor,
  output logic [2:0] fb_req,
  output logic [2:0] call_req,
  output logic       req_here,
  output logic       req_above,
  output logic       req_below,
  output logic       any_req
);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  // Channel order: [2:0] car buttons FB1..FB3, [5:3] hall buttons CALL1..CALL3.
  logic [5:0]    w_raw;
  logic [5:0]    r_sync1;
  logic [5:0]    r_sync2;
  logic [5:0]    r_deb;       // 1 = released, 0 = pressed
  logic [CW-1:0] r_cnt [6];
  logic [5:0]    w_diff;
  logic [5:0]    w_flip;
  logic [5:0]    w_press;
  logic [2:0]    w_clr;
  logic [2:0]    w_pend;

  assign w_raw  = {CALL3, CALL2, CALL1, FB3, FB2, FB1};
  assign w_diff = r_sync2 ^ r_deb;

  // A press event fires on the same edge the debounced level flips to pressed,
  // so the request bit lands on edge 2+DEB_CYCLES after the raw low is sampled.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_flip[i] = w_diff[i] && (r_cnt[i] == DEB_LAST);
    end
    w_press = w_flip & r_deb;
    for (int f = 0; f < 3; f++) begin
      w_clr[f] = svc_valid && (svc_floor == 2'(f + 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_deb    <= '1;
      // NOTE: the counter array is only six small registers, so it is reset
      // like any other state rather than treated as an uninitialised memory.
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
      fb_req   <= '0;
      call_req <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb   <= r_deb ^ w_flip;
      for (int i = 0; i < 6; i++) begin
        r_cnt[i] <= (w_diff[i] && !w_flip[i]) ? r_cnt[i] + CW'(1) : '0;
      end
      // Clear is applied last so a same-edge serve beats a new press.
      fb_req   <= (fb_req   | (w_press[2:0] & {3{accept}})) & ~w_clr;
      call_req <= (call_req | (w_press[5:3] & {3{accept}})) & ~w_clr;
    end
  end

  assign w_pend  = fb_req | call_req;
  assign any_req = |w_pend;

  // NOTE: every output of this block gets a default first so no latch is inferred
  // for cur_floor values (such as 0) that the case does not list.
  always_comb begin
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    case (cur_floor)
      2'd1: begin
        req_here  = w_pend[0];
        req_above = |w_pend[2:1];
      end
      2'd2: begin
        req_here  = w_pend[1];
        req_above = w_pend[2];
        req_below = w_pend[0];
      end
      2'd3: begin
        req_here  = w_pend[2];
        req_below = |w_pend[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_elevator_request_latch.sv
// Table-driven self-checking bench for elevator_request_latch with a scoreboard
// queue of expected output vectors {fb_req, call_req, here, above, below, any}.
module tb_elevator_request_latch;

  typedef struct {
    logic [5:0] btn;   // {CALL3,CALL2,CALL1,FB3,FB2,FB1}, active-low
    logic       acc;
    logic       sv;
    logic [1:0] sf;
    logic [1:0] cf;
    int         cyc;
    logic [9:0] exp;
  } vec_t;

  localparam int NV = 26;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] btn;
  logic       accept, svc_valid;
  logic [1:0] svc_floor, cur_floor;
  logic [2:0] fb_req, call_req;
  logic       req_here, req_above, req_below, any_req;
  logic [9:0] obs;

  logic [9:0] exp_q[$];
  vec_t       tbl[NV];
  int         n_checks = 0;
  int         n_err    = 0;

  always #5 clk = ~clk;

  elevator_request_latch dut (
    .clk(clk), .reset(reset),
    .FB1(btn[0]), .FB2(btn[1]), .FB3(btn[2]),
    .CALL1(btn[3]), .CALL2(btn[4]), .CALL3(btn[5]),
    .accept(accept), .svc_valid(svc_valid), .svc_floor(svc_floor), .cur_floor(cur_floor),
    .fb_req(fb_req), .call_req(call_req),
    .req_here(req_here), .req_above(req_above), .req_below(req_below), .any_req(any_req)
  );

  assign obs = {fb_req, call_req, req_here, req_above, req_below, any_req};

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got fb/call/h/a/b/any=%b expected %b", name, act, exp);
    end
  endtask

  task automatic compare(input string name);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, obs, e);
    end
  endtask

  task automatic drive(input logic [5:0] b, input logic a, input logic sv,
                       input logic [1:0] sf, input logic [1:0] cf);
    btn = b; accept = a; svc_valid = sv; svc_floor = sf; cur_floor = cf;
  endtask

  // Called just after a negedge: drive, run cyc rising edges, compare at the next negedge.
  task automatic apply(input vec_t v, input string name);
    drive(v.btn, v.acc, v.sv, v.sf, v.cf);
    exp_q.push_back(v.exp);
    repeat (v.cyc) @(posedge clk);
    @(negedge clk);
    compare(name);
  endtask

  initial begin
    //            btn    acc   sv    sf    cf    cyc  fb    call  h a b any
    tbl[0]  = '{6'h3F, 1'b1, 1'b0, 2'd0, 2'd1, 2, 10'b000_000_0000}; // idle
    tbl[1]  = '{6'h3D, 1'b1, 1'b0, 2'd0, 2'd1, 5, 10'b000_000_0000}; // FB2 held, edge 5
    tbl[2]  = '{6'h3D, 1'b1, 1'b0, 2'd0, 2'd1, 1, 10'b010_000_0101}; // edge 6: set
    tbl[3]  = '{6'h3F, 1'b1, 1'b0, 2'd0, 2'd2, 6, 10'b010_000_1001}; // release, here
    tbl[4]  = '{6'h1F, 1'b1, 1'b0, 2'd0, 2'd2, 3, 10'b010_000_1001}; // CALL3 glitch
    tbl[5]  = '{6'h3F, 1'b1, 1'b0, 2'd0, 2'd2, 6, 10'b010_000_1001}; // glitch rejected
    tbl[6]  = '{6'h3F, 1'b1, 1'b1, 2'd2, 2'd2, 1, 10'b000_000_0000}; // serve floor 2
    tbl[7]  = '{6'h3E, 1'b1, 1'b0, 2'd0, 2'd2, 6, 10'b001_000_0011}; // FB1 press
    tbl[8]  = '{6'h3F, 1'b1, 1'b1, 2'd0, 2'd2, 6, 10'b001_000_0011}; // svc_floor=0 ignored
    tbl[9]  = '{6'h3F, 1'b1, 1'b0, 2'd1, 2'd2, 1, 10'b001_000_0011}; // svc_valid=0 ignored
    tbl[10] = '{6'h37, 1'b1, 1'b0, 2'd0, 2'd2, 5, 10'b001_000_0011}; // CALL1 debouncing
    tbl[11] = '{6'h37, 1'b1, 1'b1, 2'd1, 2'd2, 1, 10'b000_000_0000}; // clear wins
    tbl[12] = '{6'h37, 1'b1, 1'b0, 2'd0, 2'd2, 3, 10'b000_000_0000}; // held: no re-fire
    tbl[13] = '{6'h3F, 1'b1, 1'b0, 2'd0, 2'd2, 6, 10'b000_000_0000};
    tbl[14] = '{6'h3B, 1'b0, 1'b0, 2'd0, 2'd2, 6, 10'b000_000_0000}; // FB3 with accept=0
    tbl[15] = '{6'h3B, 1'b1, 1'b0, 2'd0, 2'd2, 6, 10'b000_000_0000}; // dropped, not deferred
    tbl[16] = '{6'h3F, 1'b1, 1'b0, 2'd0, 2'd2, 6, 10'b000_000_0000};
    tbl[17] = '{6'h3B, 1'b1, 1'b0, 2'd0, 2'd2, 6, 10'b100_000_0101}; // re-press sets
    tbl[18] = '{6'h3F, 1'b1, 1'b0, 2'd0, 2'd2, 6, 10'b100_000_0101};
    tbl[19] = '{6'h17, 1'b1, 1'b0, 2'd0, 2'd2, 6, 10'b100_101_0111}; // CALL1+CALL3
    tbl[20] = '{6'h17, 1'b1, 1'b0, 2'd0, 2'd0, 1, 10'b100_101_0001}; // cur_floor=0
    tbl[21] = '{6'h17, 1'b1, 1'b0, 2'd0, 2'd3, 1, 10'b100_101_1011}; // cur_floor=3
    tbl[22] = '{6'h17, 1'b1, 1'b0, 2'd0, 2'd1, 1, 10'b100_101_1101}; // cur_floor=1
    tbl[23] = '{6'h3F, 1'b1, 1'b1, 2'd3, 2'd1, 6, 10'b000_001_1001}; // serve 3 clears both
    tbl[24] = '{6'h3F, 1'b1, 1'b0, 2'd0, 2'd1, 2, 10'b000_001_1001};
    tbl[25] = '{6'h00, 1'b1, 1'b0, 2'd0, 2'd1, 6, 10'b111_111_1101}; // all pressed, pending stays

    reset = 1'b0;
    drive(6'h3F, 1'b1, 1'b0, 2'd0, 2'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(10'b000_000_0000);
    compare("reset_state");
    reset = 1'b1;

    for (int i = 0; i < NV; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset pulsed mid-debounce of CALL2 with all requests pending.
    apply('{6'h3F, 1'b1, 1'b0, 2'd0, 2'd1, 6, 10'b111_111_1101}, "pre_reset_release");
    apply('{6'h2F, 1'b1, 1'b0, 2'd0, 2'd1, 3, 10'b111_111_1101}, "call2_mid_debounce");
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(10'b000_000_0000);
    compare("async_reset");
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(10'b000_000_0000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    compare("held_thru_reset_edge5");
    exp_q.push_back(10'b000_010_0101);
    @(posedge clk);
    @(negedge clk);
    compare("held_thru_reset_edge6");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
